// File: rtl/crypt_pkg.sv
// crypt_pkg: shared types and constants for the LFSR stream-cipher engine.
//   SPACE     - ASCII space used to pad the message front and back.
//   mode_t    - ENCRYPT / DECRYPT run mode.
//   state_t   - engine FSM states.
//   TAP_TABLE - the nine maximal-length 7-bit tap patterns, indexed by pt_no,
//               so firmware and bench pick taps from the same table.
package crypt_pkg;

  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic {
    ENCRYPT = 1'b0,
    DECRYPT = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int NUM_TAPS = 9;

  localparam logic [6:0] TAP_TABLE [NUM_TAPS] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

endpackage

// File: rtl/lfsr_gen.sv
// lfsr_gen: W-bit Fibonacci LFSR.
//   clk, rst - clock, asynchronous active-high reset (state clears to 0).
//   load     - load seed (a zero seed is replaced by 1 so the LFSR never locks up).
//   seed     - initial state.
//   step     - shift once: state <= {state[W-2:0], ^(state & taps)}.
//   taps     - feedback tap mask.
//   state    - current LFSR state.
module lfsr_gen #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  input  logic [W-1:0] taps,
  output logic [W-1:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? W'(1) : seed;
    end else if (step) begin
      state <= {state[W-2:0], ^(state & taps)};
    end
  end

endmodule

// File: rtl/lfsr_crypt_engine.sv
// lfsr_crypt_engine: memory-mapped LFSR stream-cipher accelerator.
//   Encrypt: builds a MSG_LEN-byte frame (space padding, message bytes read
//   from src_base, more padding), XORs each byte with the LFSR, puts even
//   parity in the MSB and writes the frame to dst_base.
//   Decrypt: reads MSG_LEN bytes from src_base, counts parity mismatches,
//   strips parity, XORs with the LFSR and writes plaintext to dst_base.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset (aborts a run).
//   start               - launch pulse, accepted only in IDLE.
//   cfg_mode            - 0 encrypt, 1 decrypt.
//   cfg_pre_len/msg_len - leading pad count and raw message length (encrypt).
//   cfg_taps/cfg_seed   - LFSR tap mask and seed.
//   src_base/dst_base   - source / destination region bases.
//   mem_*               - shared data-memory port; read data arrives the
//                         cycle after mem_rd_en.
//   busy/done           - run in progress / run complete (held until next start).
//   par_err_cnt         - decrypt parity mismatches of the last run (saturating).
//   dbg_state           - current FSM state.
// Handshake: start is a single-cycle request with no ready; it is taken only
// when dbg_state is IDLE (including the cycle done is high), and the result
// is signalled by done rising exactly 2*MSG_LEN+1 cycles later.
import crypt_pkg::*;

module lfsr_crypt_engine #(
  parameter int DATA_W  = 8,
  parameter int MSG_LEN = 64,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_mode,
  input  logic [ADDR_W-1:0] cfg_pre_len,
  input  logic [ADDR_W-1:0] cfg_msg_len,
  input  logic [DATA_W-2:0] cfg_taps,
  input  logic [DATA_W-2:0] cfg_seed,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] par_err_cnt,
  output state_t            dbg_state
);

  localparam int LW = DATA_W - 1;
  localparam logic [DATA_W-1:0] PAD      = DATA_W'(SPACE);
  localparam logic [ADDR_W-1:0] MSG_LEN_A = ADDR_W'(MSG_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MSG_LEN - 1);

  state_t            state;
  mode_t             mode_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] len_q;
  logic [LW-1:0]     taps_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LW-1:0]     lfsr;

  logic              accept;
  logic              is_msg;
  logic [ADDR_W:0]   msg_end;
  logic [LW-1:0]     enc_src;
  logic [LW-1:0]     enc_low;
  logic [LW-1:0]     dec_low;
  logic              dec_par_bad;

  assign accept    = (state == IDLE) && start;
  assign dbg_state = state;

  // Seed is taken straight from cfg_seed on the accept edge so byte 0 uses it.
  lfsr_gen #(.W(LW)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .seed  (cfg_seed),
    .step  (state == WR),
    .taps  (taps_q),
    .state (lfsr)
  );

  // One extra bit on the end position so pre_len+msg_len cannot wrap.
  assign msg_end     = {1'b0, pre_q} + {1'b0, len_q};
  assign is_msg      = (idx >= pre_q) && ({1'b0, idx} < msg_end);
  assign enc_src     = is_msg ? mem_rdata[LW-1:0] : PAD[LW-1:0];
  assign enc_low     = enc_src ^ lfsr;
  assign dec_low     = mem_rdata[LW-1:0] ^ lfsr;
  assign dec_par_bad = mem_rdata[DATA_W-1] != ^mem_rdata[LW-1:0];

  // Memory port is a pure decode of registered state; write data in WR
  // combines the read data returned from the preceding RD cycle.
  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (state)
      RD: begin
        if (mode_q == DECRYPT) begin
          mem_rd_en = 1'b1;
          mem_addr  = src_q + idx;
        end else if (is_msg) begin
          mem_rd_en = 1'b1;
          mem_addr  = src_q + (idx - pre_q);
        end
      end
      WR: begin
        mem_wr_en = 1'b1;
        mem_addr  = dst_q + idx;
        mem_wdata = (mode_q == ENCRYPT) ? {^enc_low, enc_low} : {1'b0, dec_low};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= ENCRYPT;
      idx         <= '0;
      pre_q       <= '0;
      len_q       <= '0;
      taps_q      <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      par_err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q      <= mode_t'(cfg_mode);
            pre_q       <= cfg_pre_len;
            len_q       <= (cfg_msg_len > MSG_LEN_A) ? MSG_LEN_A : cfg_msg_len;
            taps_q      <= cfg_taps;
            src_q       <= src_base;
            dst_q       <= dst_base;
            idx         <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            par_err_cnt <= '0;
            state       <= RD;
          end
        end
        RD: state <= WR;
        WR: begin
          if ((mode_q == DECRYPT) && dec_par_bad && (par_err_cnt != '1)) begin
            par_err_cnt <= par_err_cnt + 1'b1;
          end
          if (idx == LAST_IDX) begin
            state <= FIN;
          end else begin
            idx   <= idx + 1'b1;
            state <= RD;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// tb_lfsr_crypt_engine: directed bench for lfsr_crypt_engine with a 256-byte
// memory model, write/read window monitors and a reference cipher model.
module tb_lfsr_crypt_engine;
  import crypt_pkg::*;

  localparam int DATA_W  = 8;
  localparam int MSG_LEN = 64;
  localparam int ADDR_W  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cfg_mode = 1'b0;
  logic [7:0] cfg_pre_len = '0;
  logic [7:0] cfg_msg_len = '0;
  logic [6:0] cfg_taps = '0;
  logic [6:0] cfg_seed = '0;
  logic [7:0] src_base = '0;
  logic [7:0] dst_base = '0;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic [7:0] par_err_cnt;
  state_t     dbg_state;

  lfsr_crypt_engine #(.DATA_W(DATA_W), .MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_mode    (cfg_mode),
    .cfg_pre_len (cfg_pre_len),
    .cfg_msg_len (cfg_msg_len),
    .cfg_taps    (cfg_taps),
    .cfg_seed    (cfg_seed),
    .src_base    (src_base),
    .dst_base    (dst_base),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rdata   (mem_rdata),
    .mem_wr_en   (mem_wr_en),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .par_err_cnt (par_err_cnt),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model and monitors
  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_wa = '0;
  logic [7:0] tb_wd = '0;
  logic [7:0] win_base = '0;
  logic [7:0] rd_base = '0;
  int         rd_span = 0;
  int         wr_cnt = 0, rd_cnt = 0, bad_wr = 0, bad_rd = 0, both_cnt = 0;

  always @(posedge clk) begin
    logic [7:0] d;
    if (tb_we) mem[tb_wa] <= tb_wd;
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt++;
      d = mem_addr - rd_base;
      if (int'(d) >= rd_span) bad_rd++;
    end
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt++;
      d = mem_addr - win_base;
      if (int'(d) >= MSG_LEN) bad_wr++;
    end
    if (mem_rd_en && mem_wr_en) both_cnt++;
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int tests_run = 0;
  int fail_cnt = 0;
  string msg = " Knowledge comes, but wisdom lingers.";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic set_cfg(input logic mode, input logic [7:0] pre, input logic [7:0] len,
                         input logic [6:0] taps, input logic [6:0] seed,
                         input logic [7:0] src, input logic [7:0] dst);
    cfg_mode = mode; cfg_pre_len = pre; cfg_msg_len = len;
    cfg_taps = taps; cfg_seed = seed; src_base = src; dst_base = dst;
    win_base = dst;
  endtask

  // Launch a run; returns cycles from the accept edge until done (bounded).
  // rst_at > 0 pulses reset after that cycle; restart_at > 0 pulses start
  // with a different config while the run is busy.
  task automatic run(input int rst_at, input int restart_at, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_done_clr", done, 0);
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == restart_at);
      if (cyc == restart_at) begin
        cfg_taps = 7'h48; cfg_seed = 7'h33; dst_base = 8'h00;
        cfg_pre_len = 8'd0; cfg_msg_len = 8'd5;
      end
      if (cyc == rst_at) begin
        rst = 1'b1; #2; rst = 1'b0;
        break;
      end
      if (done) break;
    end
  endtask

  task automatic model_enc(input logic [7:0] src, input int pre, input int len,
                           input logic [6:0] taps, input logic [6:0] seed);
    logic [6:0] s, t;
    logic [7:0] b, a;
    int ml;
    exp_q.delete();
    s  = (seed == 7'd0) ? 7'd1 : seed;
    ml = (len > MSG_LEN) ? MSG_LEN : len;
    for (int i = 0; i < MSG_LEN; i++) begin
      a = src + 8'(i - pre);
      b = (i >= pre && i < pre + ml) ? mem[a] : 8'h20;
      t = b[6:0] ^ s;
      exp_q.push_back({^t, t});
      s = {s[5:0], ^(s & taps)};
    end
  endtask

  task automatic check_dst(input string tag, input logic [7:0] dst);
    logic [7:0] a;
    for (int i = 0; i < MSG_LEN; i++) begin
      a = dst + 8'(i);
      check($sformatf("%s[%0d]", tag, i), mem[a], exp_q[i]);
    end
  endtask

  initial begin
    int cyc, wr0, rd0, brd0;
    logic [6:0] rseed;
    logic [7:0] a;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_par", par_err_cnt, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_state", dbg_state, IDLE);

    // 1: all-padding encrypt, hand-computed bytes and exact latency
    set_cfg(1'b0, 8'd10, 8'd0, TAP_TABLE[0], 7'h01, 8'h00, 8'h80);
    wr0 = wr_cnt; rd0 = rd_cnt;
    run(-1, -1, cyc);
    check("t1_cycles", cyc, 129);
    check("t1_busy", busy, 0);
    check("t1_done", done, 1);
    check("t1_d0", mem[8'h80], 8'h21);
    check("t1_d1", mem[8'h81], 8'h22);
    check("t1_d5", mem[8'h85], 8'h00);
    check("t1_d6", mem[8'h86], 8'hE1);
    check("t1_writes", wr_cnt - wr0, 64);
    check("t1_reads", rd_cnt - rd0, 0);

    // 2: message encrypt with random seed
    for (int i = 0; i < msg.len(); i++) poke(8'h10 + 8'(i), msg[i]);
    rseed = 7'($urandom_range(1, 127));
    set_cfg(1'b0, 8'd12, 8'(msg.len()), TAP_TABLE[1], rseed, 8'h10, 8'h80);
    rd_base = 8'h10; rd_span = msg.len();
    model_enc(8'h10, 12, msg.len(), TAP_TABLE[1], rseed);
    wr0 = wr_cnt; rd0 = rd_cnt; brd0 = bad_rd;
    run(-1, -1, cyc);
    check("t2_cycles", cyc, 129);
    check_dst("t2_dst", 8'h80);
    check("t2_reads", rd_cnt - rd0, 37);
    check("t2_bad_reads", bad_rd - brd0, 0);

    // 3: round-trip decrypt back to the padded plaintext
    exp_q.delete();
    for (int i = 0; i < MSG_LEN; i++)
      exp_q.push_back((i >= 12 && i < 49) ? 8'(msg[i - 12]) : 8'h20);
    set_cfg(1'b1, 8'd0, 8'd0, TAP_TABLE[1], rseed, 8'h80, 8'hC0);
    rd_base = 8'h80; rd_span = 64;
    run(-1, -1, cyc);
    check("t3_cycles", cyc, 129);
    check_dst("t3_plain", 8'hC0);
    check("t3_par", par_err_cnt, 0);

    // 3b: three corrupted parity bits
    poke(8'h83, mem[8'h83] ^ 8'h80);
    poke(8'h94, mem[8'h94] ^ 8'h80);
    poke(8'hB2, mem[8'hB2] ^ 8'h80);
    run(-1, -1, cyc);
    check("t3b_par", par_err_cnt, 3);
    check("t3b_plain20", mem[8'hD4], exp_q[20]);

    // 4: seed 0 acts as seed 1
    set_cfg(1'b0, 8'd10, 8'd0, TAP_TABLE[0], 7'h00, 8'h00, 8'h40);
    run(-1, -1, cyc);
    check("t4_d0", mem[8'h40], 8'h21);
    check("t4_d6", mem[8'h46], 8'hE1);
    model_enc(8'h00, 10, 0, TAP_TABLE[0], 7'h01);
    check_dst("t4_dst", 8'h40);

    // 5: message runs past the frame; tail dropped, no write past dst+63
    for (int i = 0; i < 49; i++) poke(8'(i), 8'h41 + 8'(i % 26));
    poke(8'hC0, 8'h5A);
    set_cfg(1'b0, 8'd40, 8'd49, TAP_TABLE[2], 7'h2B, 8'h00, 8'h80);
    rd_base = 8'h00; rd_span = 24;
    model_enc(8'h00, 40, 49, TAP_TABLE[2], 7'h2B);
    wr0 = wr_cnt; rd0 = rd_cnt; brd0 = bad_rd;
    run(-1, -1, cyc);
    check_dst("t5_dst", 8'h80);
    check("t5_writes", wr_cnt - wr0, 64);
    check("t5_reads", rd_cnt - rd0, 24);
    check("t5_bad_reads", bad_rd - brd0, 0);
    check("t5_canary", mem[8'hC0], 8'h5A);
    check("t5_bad_writes", bad_wr, 0);

    // 6: reset mid-run aborts, then a fresh run completes
    set_cfg(1'b0, 8'd10, 8'd0, TAP_TABLE[0], 7'h01, 8'h00, 8'h40);
    wr0 = wr_cnt;
    run(30, -1, cyc);
    check("t6_rst_cyc", cyc, 30);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_state", dbg_state, IDLE);
    check("t6_wr_before", wr_cnt - wr0, 15);
    wr0 = wr_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_wr_after", wr_cnt - wr0, 0);
    run(-1, -1, cyc);
    check("t6_rerun_cycles", cyc, 129);
    check("t6_rerun_done", done, 1);
    check("t6_rerun_d6", mem[8'h46], 8'hE1);

    // 7: start while busy ignored; destination wraps past 0xFF
    set_cfg(1'b0, 8'd10, 8'd0, TAP_TABLE[0], 7'h01, 8'h00, 8'hF0);
    model_enc(8'h00, 10, 0, TAP_TABLE[0], 7'h01);
    wr0 = wr_cnt;
    run(-1, 20, cyc);
    check("t7_cycles", cyc, 129);
    check("t7_writes", wr_cnt - wr0, 64);
    check("t7_dF0", mem[8'hF0], 8'h21);
    check("t7_dF6", mem[8'hF6], 8'hE1);
    check("t7_d00", mem[8'h00], exp_q[16]);
    check("t7_d2F", mem[8'h2F], exp_q[63]);
    check_dst("t7_dst", 8'hF0);
    check("t7_bad_writes", bad_wr, 0);

    // 8: back-to-back start in the done/IDLE cycle
    set_cfg(1'b0, 8'd3, 8'd4, TAP_TABLE[5], 7'h55, 8'h10, 8'h60);
    model_enc(8'h10, 3, 4, TAP_TABLE[5], 7'h55);
    run(-1, -1, cyc);
    check("t8_cycles", cyc, 129);
    check_dst("t8_dst", 8'h60);
    a = 8'h60;
    check("t8_bad_writes", bad_wr, 0);
    check("t8_strobe_overlap", both_cnt, 0);
    check("t8_d0", mem[a], exp_q[0]);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/lfsr_crypt_engine.md
Name: lfsr_crypt_engine

Overview:
- Hardware LFSR stream-cipher engine. It replaces the software encrypt program for the CSE141L message-encryption task.
- Reads a message from data memory and pads it front and back with ASCII space (0x20).
- Encrypt: XORs each byte with a configurable Fibonacci LFSR, puts even parity in the MSB, writes MSG_LEN bytes to a destination region.
- Decrypt: checks parity, strips it, XORs, and counts parity errors. Sits beside the core as a memory-mapped accelerator sharing the data-memory port.

Parameters:
- DATA_W, 8, byte width; LFSR width is DATA_W-1.
- MSG_LEN, 64, output bytes per run.
- ADDR_W, 8, data-memory address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle launch pulse; ignored while busy.
- cfg_mode  in  1  0 = encrypt, 1 = decrypt.
- cfg_pre_len  in  ADDR_W  leading pad bytes (encrypt only).
- cfg_msg_len  in  ADDR_W  raw message length (encrypt only).
- cfg_taps  in  DATA_W-1  feedback tap mask.
- cfg_seed  in  DATA_W-1  LFSR initial state.
- src_base  in  ADDR_W  source region base address.
- dst_base  in  ADDR_W  destination region base address.
- mem_addr  out  ADDR_W  memory address.
- mem_rd_en  out  1  read strobe; data returned next cycle.
- mem_rdata  in  DATA_W  read data.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  DATA_W  write data.
- busy  out  1  run in progress.
- done  out  1  run complete; level held until next accepted start.
- par_err_cnt  out  ADDR_W  decrypt parity mismatches in last run.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; LFSR 0.
- Reset asserted mid-run: abort immediately, no further writes, memory contents left as-is.
- Config latch: on start in IDLE, latch all cfg_*, src_base and dst_base. Clear done and par_err_cnt. Set busy. Byte index i = 0.
- Seed: cfg_seed==0 is replaced by 1.
- Clipping: msg_len > MSG_LEN is clipped to MSG_LEN. Byte positions at or beyond MSG_LEN are dropped.
- FSM states: IDLE -> RD -> WR -> (RD if i<MSG_LEN-1, else FIN) -> IDLE.
- Timing: every byte takes exactly 2 cycles. done rises 2*MSG_LEN+1 cycles after the accepted start edge.
- RD, encrypt:
  - Byte i is message when pre_len <= i < pre_len+msg_len.
  - If message: mem_rd_en=1, mem_addr = src_base + (i - pre_len).
  - Otherwise no read; the byte is 0x20.
- RD, decrypt: always read, mem_addr = src_base + i.
- WR, encrypt:
  - t = byte ^ {0, lfsr}.
  - mem_wdata = {^t[DATA_W-2:0], t[DATA_W-2:0]}.
  - mem_addr = dst_base + i, mem_wr_en=1.
- WR, decrypt:
  - If rdata[MSB] != ^rdata[DATA_W-2:0], par_err_cnt increments (saturating).
  - mem_wdata = {0, rdata[DATA_W-2:0] ^ lfsr}.
- LFSR step in WR: lfsr <= {lfsr[W-2:0], ^(lfsr & taps)}. Byte 0 uses the seed.
- FIN: busy=0, done=1. done stays high until the next start is accepted.
- Address arithmetic: modulo 2^ADDR_W; wrap-around allowed.
- Strobes: mem_rd_en and mem_wr_en are never high in the same cycle.
- Back-to-back runs: start in the same cycle as done/IDLE is accepted.

Decomposition:
- crypt_pkg holds:
  - SPACE = 8'h20.
  - mode_t enum {ENCRYPT, DECRYPT}.
  - state_t enum {IDLE, RD, WR, FIN}.
  - The 9 legal 7-bit maximal tap patterns 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B as a constant array, so software and bench index by pt_no.
- One sub-module, lfsr_gen, parametrised by W, with ports clk, rst, load, seed, step, taps, state.

Test Plan:
- Encrypt, taps 0x60, seed 0x01, pre_len 10, msg_len 0 -> dst[0]=0x21, dst[1]=0x22, dst[5]=0x00, dst[6]=0xE1; done exactly 129 cycles after start.
- Encrypt, taps 0x48, random seed, pre_len 12, message " Knowledge comes, but wisdom lingers." -> all 64 dst bytes match the golden model; reads occur only for i in [12,49).
- Round trip: decrypt the previous output with the same seed and taps -> dst equals the padded plaintext; par_err_cnt=0. Flip bit 7 of 3 source bytes -> par_err_cnt=3.
- cfg_seed=0 -> behaves identically to seed 1. pre_len=40, msg_len=49 -> bytes beyond 63 dropped, no write outside dst_base..dst_base+63.
- rst pulsed at cycle 30 of a run -> busy=0, done=0, no writes after reset; a new start completes normally.
- start pulsed while busy -> ignored (config unchanged, timing unchanged). dst_base=0xF0 -> writes wrap to 0x00..0x2F.
